rob_queue: RTL and testbench

ROB_QUEUE -- requirements
Module: rob_queue

---
 rtl/rob_queue.sv | 168 ++++++++++++++++
 tb/tb_rob_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_queue.sv
// Reorder buffer: circular queue of in-flight instructions with multi-port writeback,
// in-order commit and tag-based mispredict rollback.

module rob_entry #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc,
    input  logic [ADDR_WIDTH-1:0] alloc_pc,
    input  logic [5:0]            alloc_reg_dest,
    input  logic                  kill,
    input  logic                  wb,
    input  logic [DATA_WIDTH-1:0] wb_value,
    output logic                  valid,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [5:0]            reg_dest,
    output logic [DATA_WIDTH-1:0] value
);

    // Kill outranks writeback so a result landing on a flushed/committed slot is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            ready    <= 1'b0;
            pc       <= '0;
            reg_dest <= '0;
            value    <= '0;
        end else if (alloc) begin
            valid    <= 1'b1;
            ready    <= 1'b0;
            pc       <= alloc_pc;
            reg_dest <= alloc_reg_dest;
        end else if (kill) begin
            valid <= 1'b0;
            ready <= 1'b0;
        end else if (wb) begin
            ready <= 1'b1;
            value <= wb_value;
        end
    end

endmodule

module rob_queue #(
    parameter int DEPTH      = 8,
    parameter int DEPTH_BITS = 3,
    parameter int WB_PORTS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           alloc_valid,
    input  logic [ADDR_WIDTH-1:0]          alloc_pc,
    input  logic [5:0]                     alloc_reg_dest,
    output logic                           alloc_ready,
    output logic [DEPTH_BITS-1:0]          alloc_tag,
    input  logic [WB_PORTS-1:0]            wb_valid,
    input  logic [WB_PORTS*DEPTH_BITS-1:0] wb_tag,
    input  logic [WB_PORTS*DATA_WIDTH-1:0] wb_value,
    output logic                           commit_valid,
    input  logic                           commit_ready,
    output logic [DEPTH_BITS-1:0]          commit_tag,
    output logic [ADDR_WIDTH-1:0]          commit_pc,
    output logic [5:0]                     commit_reg_dest,
    output logic [DATA_WIDTH-1:0]          commit_value,
    input  logic                           flush_valid,
    input  logic [DEPTH_BITS-1:0]          flush_tag,
    output logic [DEPTH_BITS:0]            count
);

    localparam int CW = DEPTH_BITS + 1;
    typedef logic [DEPTH_BITS-1:0] ptr_t;

    ptr_t          head, tail, flush_age, wt;
    logic [CW-1:0] cnt;
    logic          alloc_fire, commit_fire, flush_hit;

    logic [DEPTH-1:0]                 ent_valid, ent_ready, ent_alloc, ent_kill, ent_wb;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_pc;
    logic [DEPTH-1:0][5:0]            ent_rd;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_value, ent_wb_value;

    assign count       = cnt;
    assign alloc_tag   = tail;
    assign alloc_ready = (cnt < CW'(DEPTH)) && !flush_valid;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign commit_valid    = ent_valid[head] && ent_ready[head];
    assign commit_fire     = commit_valid && commit_ready;
    assign commit_tag      = head;
    assign commit_pc       = ent_pc[head];
    assign commit_reg_dest = ent_rd[head];
    assign commit_value    = ent_value[head];

    assign flush_hit = flush_valid && ent_valid[flush_tag];
    assign flush_age = flush_tag - head;

    // Channels are scanned low to high so the highest-indexed hit on a tag wins.
    always_comb begin
        ent_wb       = '0;
        ent_wb_value = '0;
        wt           = '0;
        for (int c = 0; c < WB_PORTS; c++) begin
            wt = wb_tag[c*DEPTH_BITS +: DEPTH_BITS];
            if (wb_valid[c] && ent_valid[wt]) begin
                ent_wb[wt]       = 1'b1;
                ent_wb_value[wt] = wb_value[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Age is distance from head; anything older than the flush point survives.
    always_comb begin
        ent_kill  = '0;
        ent_alloc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_kill[i]  = (commit_fire && head == ptr_t'(i)) ||
                           (flush_hit && ent_valid[i] && ptr_t'(ptr_t'(i) - head) > flush_age);
            ent_alloc[i] = alloc_fire && tail == ptr_t'(i);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rob_entry #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_ent (
            .clk           (clk),
            .rst_n         (rst_n),
            .alloc         (ent_alloc[g]),
            .alloc_pc      (alloc_pc),
            .alloc_reg_dest(alloc_reg_dest),
            .kill          (ent_kill[g]),
            .wb            (ent_wb[g]),
            .wb_value      (ent_wb_value[g]),
            .valid         (ent_valid[g]),
            .ready         (ent_ready[g]),
            .pc            (ent_pc[g]),
            .reg_dest      (ent_rd[g]),
            .value         (ent_value[g])
        );
    end

    // A flush never coincides with alloc (alloc_ready is low), so only commit adjusts its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (commit_fire)
                head <= head + ptr_t'(1);
            if (flush_hit)
                tail <= flush_tag + ptr_t'(1);
            else if (alloc_fire)
                tail <= tail + ptr_t'(1);
            if (flush_hit)
                cnt <= {1'b0, flush_age} + CW'(1) - CW'(commit_fire);
            else
                cnt <= cnt + CW'(alloc_fire) - CW'(commit_fire);
        end
    end

endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue (DEPTH=4, two writeback ports) with a commit scoreboard.

module tb_rob_queue;

    logic        clk, rst_n;
    logic        alloc_valid, alloc_ready;
    logic [25:0] alloc_pc, commit_pc;
    logic [5:0]  alloc_reg_dest, commit_reg_dest;
    logic [1:0]  alloc_tag, commit_tag, flush_tag;
    logic [1:0]  wb_valid;
    logic [3:0]  wb_tag;
    logic [63:0] wb_value;
    logic        commit_valid, commit_ready, flush_valid;
    logic [31:0] commit_value;
    logic [2:0]  count;

    rob_queue #(
        .DEPTH(4), .DEPTH_BITS(2), .WB_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(26)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_reg_dest(alloc_reg_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
        .commit_pc(commit_pc), .commit_reg_dest(commit_reg_dest), .commit_value(commit_value),
        .flush_valid(flush_valid), .flush_tag(flush_tag), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  tag;
        logic [25:0] pc;
        logic [5:0]  rd;
        logic [31:0] val;
    } cexp_t;
    cexp_t sb[$];
    cexp_t mon_e;

    typedef struct {
        logic        av;
        logic [25:0] pc;
        logic [5:0]  rd;
        logic        exp_ready;
        logic [1:0]  exp_tag;
        logic [2:0]  exp_count;
        logic        exp_cv;
    } vec_t;
    vec_t fill_tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [25:0] p, input logic [5:0] r, input logic [31:0] v);
        cexp_t e;
        e.tag = t; e.pc = p; e.rd = r; e.val = v;
        sb.push_back(e);
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_pc = '0; alloc_reg_dest = '0;
        wb_valid = '0; wb_tag = '0; wb_value = '0;
        commit_ready = 0; flush_valid = 0; flush_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted commit must match the next expected retirement.
    always @(negedge clk) begin
        if (rst_n && commit_valid && commit_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL commit_unexpected: got tag %0d, expected no commit", commit_tag);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_tag", commit_tag, mon_e.tag);
                chk("sb_pc", commit_pc, mon_e.pc);
                chk("sb_rd", commit_reg_dest, mon_e.rd);
                chk("sb_value", commit_value, mon_e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        fill_tbl[0] = '{1'b1, 26'h10, 6'd1, 1'b1, 2'd0, 3'd0, 1'b0};
        fill_tbl[1] = '{1'b1, 26'h11, 6'd2, 1'b1, 2'd1, 3'd1, 1'b0};
        fill_tbl[2] = '{1'b1, 26'h12, 6'd3, 1'b1, 2'd2, 3'd2, 1'b0};
        fill_tbl[3] = '{1'b1, 26'h13, 6'd4, 1'b1, 2'd3, 3'd3, 1'b0};
        fill_tbl[4] = '{1'b1, 26'h14, 6'd5, 1'b0, 2'd0, 3'd4, 1'b0};

        rst_n = 0;
        idle();
        #2;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_count", count, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_pc", commit_pc, 0);
        tick(); tick();
        rst_n = 1;

        // Fill to full; fifth request refused
        for (int k = 0; k < 5; k++) begin
            idle();
            alloc_valid = fill_tbl[k].av; alloc_pc = fill_tbl[k].pc; alloc_reg_dest = fill_tbl[k].rd;
            #1;
            chk("fill_alloc_ready", alloc_ready, fill_tbl[k].exp_ready);
            chk("fill_alloc_tag", alloc_tag, fill_tbl[k].exp_tag);
            chk("fill_count", count, fill_tbl[k].exp_count);
            chk("fill_commit_valid", commit_valid, fill_tbl[k].exp_cv);
            tick();
        end
        idle(); #1;
        chk("full_count", count, 4);

        // Out-of-order writeback: tag2 then tag0
        tick();
        idle(); commit_ready = 1; wb_valid = 2'b01; wb_tag = 4'b0010; wb_value = {32'h0, 32'hAA};
        #1; chk("ooo_cv_a", commit_valid, 0);
        tick();
        idle(); commit_ready = 1; wb_valid = 2'b01; wb_tag = 4'b0000; wb_value = {32'h0, 32'h55};
        #1; chk("ooo_cv_b", commit_valid, 0);
        tick();
        push(2'd0, 26'h10, 6'd1, 32'h55);
        idle(); commit_ready = 1;
        #1;
        chk("ooo_cv_c", commit_valid, 1);
        chk("ooo_value_c", commit_value, 32'h55);
        tick();
        idle(); commit_ready = 1;
        #1;
        chk("ooo_stall_cv", commit_valid, 0);
        chk("ooo_stall_tag", commit_tag, 1);
        chk("ooo_count", count, 3);
        tick();

        // Both channels hit tag1: channel 1 wins
        idle(); commit_ready = 1; wb_valid = 2'b11; wb_tag = 4'b0101; wb_value = {32'h2, 32'h1};
        #1; chk("coll_cv_pre", commit_valid, 0);
        tick();
        push(2'd1, 26'h11, 6'd2, 32'h2);
        push(2'd2, 26'h12, 6'd3, 32'hAA);
        idle(); commit_ready = 1;
        #1;
        chk("coll_value", commit_value, 32'h2);
        chk("coll_cv", commit_valid, 1);
        tick();
        idle(); commit_ready = 1;
        #1; chk("c2_value", commit_value, 32'hAA);
        tick();
        idle(); commit_ready = 1;
        #1;
        chk("h3_cv", commit_valid, 0);
        chk("h3_count", count, 1);
        chk("h3_alloc_tag", alloc_tag, 0);
        tick();

        // Wrap: head=3, alloc tag0 while writing tag3
        idle(); alloc_valid = 1; alloc_pc = 26'h20; alloc_reg_dest = 6'd5;
        wb_valid = 2'b01; wb_tag = 4'b0011; wb_value = {32'h0, 32'h33};
        #1; chk("wrap_alloc_tag0", alloc_tag, 0);
        tick();
        push(2'd3, 26'h13, 6'd4, 32'h33);
        idle(); alloc_valid = 1; alloc_pc = 26'h21; alloc_reg_dest = 6'd6; commit_ready = 1;
        #1;
        chk("sim_cv", commit_valid, 1);
        chk("sim_alloc_tag", alloc_tag, 1);
        chk("sim_count_pre", count, 2);
        tick();
        idle(); wb_valid = 2'b01; wb_tag = 4'b0000; wb_value = {32'h0, 32'h44};
        #1;
        chk("sim_count_post", count, 2);
        chk("sim_tail", alloc_tag, 2);
        chk("sim_head", commit_tag, 0);
        tick();

        // Flush at the committing head: queue empties
        push(2'd0, 26'h20, 6'd5, 32'h44);
        idle(); flush_valid = 1; flush_tag = 2'd0; commit_ready = 1;
        alloc_valid = 1; alloc_pc = 26'h3F;
        #1;
        chk("fc_alloc_ready", alloc_ready, 0);
        chk("fc_cv", commit_valid, 1);
        tick();
        idle(); #1;
        chk("fc_count", count, 0);
        chk("fc_tail", alloc_tag, 1);
        chk("fc_head", commit_tag, 1);
        chk("fc_cv_post", commit_valid, 0);

        // Fresh run: fill, then flush to tag1 with a same-cycle wb to tag3
        rst_n = 0; tick(); tick(); rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            idle(); alloc_valid = 1; alloc_pc = 26'h30 + 26'(k); alloc_reg_dest = 6'd8 + 6'(k);
            tick();
        end
        idle(); flush_valid = 1; flush_tag = 2'd1;
        wb_valid = 2'b10; wb_tag = 4'b1100; wb_value = {32'h99, 32'h0};
        #1;
        chk("fl_alloc_ready", alloc_ready, 0);
        chk("fl_count_pre", count, 4);
        tick();
        idle(); #1;
        chk("fl_count", count, 2);
        chk("fl_tail", alloc_tag, 2);
        chk("fl_alloc_ready_post", alloc_ready, 1);
        tick();
        idle(); wb_valid = 2'b11; wb_tag = 4'b0100; wb_value = {32'h101, 32'h100};
        tick();
        push(2'd0, 26'h30, 6'd8, 32'h100);
        push(2'd1, 26'h31, 6'd9, 32'h101);
        idle(); commit_ready = 1; tick();
        idle(); commit_ready = 1; tick();
        idle(); #1;
        chk("fl_drain_cv", commit_valid, 0);
        chk("fl_drain_count", count, 0);
        idle(); alloc_valid = 1; alloc_pc = 26'h40; alloc_reg_dest = 6'd12;
        #1; chk("fl_next_tag", alloc_tag, 2);
        tick();
        idle(); alloc_valid = 1; alloc_pc = 26'h41; alloc_reg_dest = 6'd13;
        #1; chk("fl_tag3_cv", commit_valid, 0);
        tick();
        idle(); alloc_valid = 1; alloc_pc = 26'h42; alloc_reg_dest = 6'd14;
        wb_valid = 2'b01; wb_tag = 4'b0010; wb_value = {32'h0, 32'h77};
        tick();
        idle(); #1;
        chk("pre_rst_count", count, 3);
        chk("pre_rst_cv", commit_valid, 1);
        chk("pre_rst_pc", commit_pc, 26'h40);
        chk("pre_rst_value", commit_value, 32'h77);

        // Reset mid-run: outputs clear immediately
        rst_n = 0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_alloc_tag", alloc_tag, 0);
        chk("mid_rst_alloc_ready", alloc_ready, 1);
        chk("mid_rst_cv", commit_valid, 0);
        chk("mid_rst_tag", commit_tag, 0);
        chk("mid_rst_pc", commit_pc, 0);
        chk("mid_rst_rd", commit_reg_dest, 0);
        chk("mid_rst_value", commit_value, 0);
        tick();
        rst_n = 1;
        idle(); alloc_valid = 1; alloc_pc = 26'h50; alloc_reg_dest = 6'd1;
        #1; chk("post_rst_tag", alloc_tag, 0);
        tick();
        idle(); #1;
        chk("post_rst_count", count, 1);
        chk("post_rst_tail", alloc_tag, 1);

        chk("sb_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
